// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer between program ROM and command buffer
//
// Purpose: walks the PC through program ROM and pushes each 14-bit word into
// the command buffer strictly in order. A word rejected by a full buffer is
// held and retried (STALL) while the ROM pipeline restarts behind it. The
// block hands paired words to DECODE, tracks buffer occupancy, and handles
// branch redirect/flush and halt.
//
// Ports:
//   clk, reset          posedge clock, synchronous active-high reset
//   run                 start fetching from IDLE
//   halt                stop issuing ROM reads, drain pending word, go IDLE
//   redirect            branch taken (1-cycle pulse), new PC on redirect_addr
//   rom_en, rom_addr    ROM read request
//   rom_data            ROM word, valid one cycle after rom_en
//   buf_write, buf_wdata  word write to the command buffer
//   buf_full            buffer rejects the write presented this cycle
//   decode_ready        DECODE requests a command
//   buf_read            pops one command (two words) from the buffer
//   flush               one-cycle clear pulse to buffer and DECODE
//   occupancy           words currently held in the buffer
//   state               0 IDLE, 1 FETCH, 2 STALL, 3 FLUSH
//
// Build option: define FETCH_STATS_EN to add the stall_cycles (16-bit) and
// flush_count (8-bit) saturating counter outputs.

module fetch_sequencer #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12,
  parameter int REGS   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    halt,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_addr,
  output logic                    rom_en,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    buf_write,
  output logic [DATA_W-1:0]       buf_wdata,
  input  logic                    buf_full,
  input  logic                    decode_ready,
  output logic                    buf_read,
  output logic                    flush,
  output logic [$clog2(REGS):0]   occupancy,
`ifdef FETCH_STATS_EN
  output logic [15:0]             stall_cycles,
  output logic [7:0]              flush_count,
`endif
  output logic [1:0]              state
);

  localparam int OCC_W = $clog2(REGS) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_pc;
  logic                r_inflight;       // ROM read issued last cycle, data on rom_data now
  logic [ADDR_W-1:0]   r_inflight_addr;
  logic                r_wr_valid;       // word presented on buf_write; doubles as the skid
  logic [DATA_W-1:0]   r_wr_data;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [OCC_W-1:0]    r_occ;
  logic                r_halting;

  logic                w_flush_req;
  logic                w_occ_full;
  logic                w_halting;
  logic                w_rom_en;
  logic                w_buf_write;
  logic                w_reject;
  logic                w_accept;
  logic                w_buf_read;

  // Redirect in IDLE only reloads the PC; everywhere else it flushes.
  assign w_flush_req = redirect && (r_state != S_IDLE);
  assign w_occ_full  = (r_occ == OCC_W'(REGS));
  assign w_halting   = halt || r_halting;
  assign w_rom_en    = (r_state == S_FETCH) && !w_halting;

  // A full occupancy count withholds the strobe but is treated exactly like a
  // buffer rejection, so the word parks in the skid and the PC rewinds.
  assign w_buf_write = r_wr_valid && !w_occ_full;
  assign w_reject    = r_wr_valid && (buf_full || w_occ_full);
  assign w_accept    = w_buf_write && !buf_full;
  assign w_buf_read  = decode_ready && (r_occ >= OCC_W'(2)) &&
                       (r_state != S_FLUSH) && !w_flush_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    rom_en       = w_rom_en;
    rom_addr     = r_pc;
    buf_write    = w_buf_write;
    buf_wdata    = r_wr_data;
    buf_read     = w_buf_read;
    flush        = (r_state == S_FLUSH);
    occupancy    = r_occ;
    state        = r_state;
    case (r_state)
      S_IDLE:  if (run) w_state_next = S_FETCH;
      S_FETCH: begin
        if (w_reject) begin
          w_state_next = S_STALL;
        end else if (w_halting && !r_inflight && !r_wr_valid) begin
          w_state_next = S_IDLE;
        end
      end
      S_STALL: if (w_accept) w_state_next = w_halting ? S_IDLE : S_FETCH;
      S_FLUSH: w_state_next = S_FETCH;
      default: w_state_next = S_IDLE;
    endcase
    if (w_flush_req) w_state_next = S_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc            <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
      r_wr_valid      <= 1'b0;
      r_wr_data       <= '0;
      r_wr_addr       <= '0;
      r_occ           <= '0;
      r_halting       <= 1'b0;
    end else if (w_flush_req) begin
      r_pc       <= redirect_addr;
      r_inflight <= 1'b0;
      r_wr_valid <= 1'b0;
      r_occ      <= '0;
      r_halting  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && redirect) begin
        r_pc <= redirect_addr;
      end else if (w_reject) begin
        // Refetch right behind the parked word; reads issued after it are dropped.
        r_pc <= r_wr_addr + ADDR_W'(1);
      end else if (w_rom_en) begin
        r_pc <= r_pc + ADDR_W'(1);
      end

      r_inflight      <= w_rom_en && !w_reject;
      r_inflight_addr <= r_pc;

      // On a reject the presented word is held (skid) and the word arriving
      // from ROM this cycle is discarded; it will be fetched again.
      if (!w_reject) begin
        r_wr_valid <= r_inflight;
        if (r_inflight) begin
          r_wr_data <= rom_data;
          r_wr_addr <= r_inflight_addr;
        end
      end

      r_occ <= r_occ + OCC_W'(w_accept) - (w_buf_read ? OCC_W'(2) : OCC_W'(0));

      if (w_state_next == S_IDLE) begin
        r_halting <= 1'b0;
      end else if (((r_state == S_FETCH) || (r_state == S_STALL)) && halt) begin
        r_halting <= 1'b1;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if ((r_state == S_STALL) && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_flush_req && (r_flush_count != 8'hFF)) begin
        r_flush_count <= r_flush_count + 8'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        halt;
  logic        redirect;
  logic [11:0] redirect_addr;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [13:0] rom_data;
  logic        buf_write;
  logic [13:0] buf_wdata;
  logic        buf_full;
  logic        decode_ready;
  logic        buf_read;
  logic        flush;
  logic [4:0]  occupancy;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  logic [13:0] sb[$];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .redirect(redirect),
    .redirect_addr(redirect_addr), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .buf_write(buf_write), .buf_wdata(buf_wdata),
    .buf_full(buf_full), .decode_ready(decode_ready), .buf_read(buf_read),
    .flush(flush), .occupancy(occupancy), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word at address a is a+1, returned one cycle after rom_en.
  always @(posedge clk) begin
    if (rom_en) rom_data <= {2'b00, rom_addr} + 14'd1;
  end

  // Record every word the buffer actually accepts.
  always @(negedge clk) begin
    if (!reset && buf_write && !buf_full) sb.push_back(buf_wdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench inside cycle c0: DUT in reset state, reset released for the next edge.
  task automatic do_reset();
    reset = 1'b1; run = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_addr = '0;
    buf_full = 1'b0; decode_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en got %b exp 0", rom_en); end
    checks++; if (rom_addr !== 12'h000) begin errors++; $display("FAIL reset_rom_addr got %0h exp 0", rom_addr); end
    checks++; if (buf_write !== 1'b0) begin errors++; $display("FAIL reset_buf_write got %b exp 0", buf_write); end
    checks++; if (buf_wdata !== 14'h0) begin errors++; $display("FAIL reset_buf_wdata got %0h exp 0", buf_wdata); end
    checks++; if (buf_read !== 1'b0) begin errors++; $display("FAIL reset_buf_read got %b exp 0", buf_read); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    run = 1'b1;
    tick(); run = 1'b0; #1;                                            // c1
    checks++; if (rom_en !== 1'b1 || rom_addr !== 12'h000) begin errors++; $display("FAIL basic_first_addr got en=%b addr=%0h exp en=1 addr=0", rom_en, rom_addr); end
    tick(); #1;                                                        // c2
    checks++; if (buf_write !== 1'b0) begin errors++; $display("FAIL basic_no_early_write got %b exp 0", buf_write); end
    for (int k = 0; k < 4; k++) begin                                  // c3..c6
      tick(); #1;
      checks++; if (buf_write !== 1'b1 || buf_wdata !== 14'(k + 1)) begin errors++; $display("FAIL basic_write%0d got wr=%b data=%0h exp wr=1 data=%0h", k, buf_write, buf_wdata, k + 1); end
    end
    tick(); halt = 1'b1; #1;                                           // c7
    checks++; if (occupancy !== 5'd4) begin errors++; $display("FAIL basic_occ4 got %0d exp 4", occupancy); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL basic_halt_rom_en got %b exp 0", rom_en); end
    for (int i = 0; i < 40 && state !== 2'd0; i++) begin tick(); #1; end
    halt = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL basic_halt_idle got %0d exp 0", state); end
    checks++; if (occupancy !== 5'd6) begin errors++; $display("FAIL basic_drain_occ got %0d exp 6", occupancy); end
    checks++; if (rom_addr !== 12'h006) begin errors++; $display("FAIL basic_halt_pc got %0h exp 6", rom_addr); end
    checks++; if (sb.size() != 6) begin errors++; $display("FAIL basic_sb_size got %0d exp 6", sb.size()); end
    for (int i = 0; i < sb.size(); i++) begin
      checks++; if (sb[i] !== 14'(i + 1)) begin errors++; $display("FAIL basic_order%0d got %0h exp %0h", i, sb[i], i + 1); end
    end
  endtask

  task automatic test_full_retry();
    do_reset();
    run = 1'b1;
    tick(); run = 1'b0;                                                // c1
    for (int k = 2; k <= 7; k++) tick();                               // c7
    tick(); buf_full = 1'b1; #1;                                       // c8: ROM[5] presented
    checks++; if (buf_write !== 1'b1 || buf_wdata !== 14'h6 || state !== 2'd1) begin errors++; $display("FAIL retry_first got wr=%b data=%0h st=%0d exp wr=1 data=6 st=1", buf_write, buf_wdata, state); end
    for (int k = 9; k <= 11; k++) begin                                // c9..c11
      tick(); buf_full = (k != 11); #1;
      checks++; if (state !== 2'd2 || buf_write !== 1'b1 || buf_wdata !== 14'h6 || rom_en !== 1'b0) begin errors++; $display("FAIL retry_stall_c%0d got st=%0d wr=%b data=%0h en=%b exp st=2 wr=1 data=6 en=0", k, state, buf_write, buf_wdata, rom_en); end
    end
    tick(); #1;                                                        // c12
    checks++; if (state !== 2'd1 || rom_en !== 1'b1 || rom_addr !== 12'h006) begin errors++; $display("FAIL retry_resume got st=%0d en=%b addr=%0h exp st=1 en=1 addr=6", state, rom_en, rom_addr); end
    tick(); #1;                                                        // c13
    checks++; if (buf_write !== 1'b0) begin errors++; $display("FAIL retry_gap got %b exp 0", buf_write); end
    tick(); #1;                                                        // c14
    checks++; if (buf_write !== 1'b1 || buf_wdata !== 14'h7) begin errors++; $display("FAIL retry_next got wr=%b data=%0h exp wr=1 data=7", buf_write, buf_wdata); end
    tick(); halt = 1'b1; #1;                                           // c15
    for (int i = 0; i < 40 && state !== 2'd0; i++) begin tick(); #1; end
    halt = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL retry_idle got %0d exp 0", state); end
    checks++; if (occupancy !== 5'd9 || rom_addr !== 12'h009) begin errors++; $display("FAIL retry_final got occ=%0d pc=%0h exp occ=9 pc=9", occupancy, rom_addr); end
    checks++; if (sb.size() != 9) begin errors++; $display("FAIL retry_sb_size got %0d exp 9", sb.size()); end
    for (int i = 0; i < sb.size(); i++) begin
      checks++; if (sb[i] !== 14'(i + 1)) begin errors++; $display("FAIL retry_order%0d got %0h exp %0h", i, sb[i], i + 1); end
    end
  endtask

  task automatic test_decode_read();
    do_reset();
    run = 1'b1;
    tick(); run = 1'b0;                                                // c1
    tick(); tick();                                                    // c3
    tick(); halt = 1'b1;                                               // c4
    for (int i = 0; i < 40 && state !== 2'd0; i++) begin tick(); #1; end
    halt = 1'b0;
    checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL read_pre_occ got %0d exp 3", occupancy); end
    tick(); decode_ready = 1'b1; #1;
    checks++; if (buf_read !== 1'b1) begin errors++; $display("FAIL read_pulse got %b exp 1", buf_read); end
    tick(); #1;
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL read_post_occ got %0d exp 1", occupancy); end
    checks++; if (buf_read !== 1'b0) begin errors++; $display("FAIL read_underflow got %b exp 0", buf_read); end
    tick(); decode_ready = 1'b0; #1;
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL read_hold_occ got %0d exp 1", occupancy); end
  endtask

  task automatic test_redirect();
    do_reset();
    run = 1'b1;
    tick(); run = 1'b0;                                                // c1
    for (int k = 2; k <= 16; k++) tick();                              // c16
    tick(); redirect = 1'b1; redirect_addr = 12'h200; decode_ready = 1'b1; #1;  // c17
    checks++; if (rom_en !== 1'b1 || rom_addr !== 12'h010) begin errors++; $display("FAIL redir_at_pc got en=%b addr=%0h exp en=1 addr=10", rom_en, rom_addr); end
    checks++; if (occupancy !== 5'd14) begin errors++; $display("FAIL redir_pre_occ got %0d exp 14", occupancy); end
    checks++; if (buf_read !== 1'b0) begin errors++; $display("FAIL redir_read_suppress got %b exp 0", buf_read); end
    tick(); redirect = 1'b0; decode_ready = 1'b0; #1;                  // c18
    checks++; if (state !== 2'd3 || flush !== 1'b1) begin errors++; $display("FAIL redir_flush got st=%0d flush=%b exp st=3 flush=1", state, flush); end
    checks++; if (occupancy !== 5'd0 || buf_write !== 1'b0 || rom_en !== 1'b0) begin errors++; $display("FAIL redir_clear got occ=%0d wr=%b en=%b exp 0 0 0", occupancy, buf_write, rom_en); end
    tick(); #1;                                                        // c19
    checks++; if (flush !== 1'b0 || state !== 2'd1 || rom_en !== 1'b1 || rom_addr !== 12'h200) begin errors++; $display("FAIL redir_resume got flush=%b st=%0d en=%b addr=%0h exp 0 1 1 200", flush, state, rom_en, rom_addr); end
    tick(); #1;                                                        // c20
    checks++; if (buf_write !== 1'b0) begin errors++; $display("FAIL redir_dropped got %b exp 0", buf_write); end
    tick(); #1;                                                        // c21
    checks++; if (buf_write !== 1'b1 || buf_wdata !== 14'h201) begin errors++; $display("FAIL redir_first got wr=%b data=%0h exp wr=1 data=201", buf_write, buf_wdata); end
    tick(); #1;                                                        // c22
    checks++; if (sb.size() != 16) begin errors++; $display("FAIL redir_sb_size got %0d exp 16", sb.size()); end
    else begin
      checks++; if (sb[14] !== 14'h00F || sb[15] !== 14'h201) begin errors++; $display("FAIL redir_sb_tail got %0h %0h exp f 201", sb[14], sb[15]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_addr = 12'hFFE;                          // c0 in IDLE
    tick(); redirect = 1'b0; run = 1'b1; #1;                           // c1
    checks++; if (state !== 2'd0 || flush !== 1'b0 || rom_addr !== 12'hFFE) begin errors++; $display("FAIL wrap_idle_redir got st=%0d flush=%b pc=%0h exp 0 0 ffe", state, flush, rom_addr); end
    tick(); run = 1'b0; #1;                                            // c2
    checks++; if (rom_en !== 1'b1 || rom_addr !== 12'hFFE) begin errors++; $display("FAIL wrap_ffe got en=%b addr=%0h exp 1 ffe", rom_en, rom_addr); end
    tick(); #1;                                                        // c3
    checks++; if (rom_addr !== 12'hFFF) begin errors++; $display("FAIL wrap_fff got %0h exp fff", rom_addr); end
    tick(); #1;                                                        // c4
    checks++; if (rom_addr !== 12'h000) begin errors++; $display("FAIL wrap_zero got %0h exp 0", rom_addr); end
    checks++; if (buf_write !== 1'b1 || buf_wdata !== 14'h0FFF) begin errors++; $display("FAIL wrap_w0 got wr=%b data=%0h exp 1 fff", buf_write, buf_wdata); end
    tick(); #1;                                                        // c5
    checks++; if (buf_wdata !== 14'h1000) begin errors++; $display("FAIL wrap_w1 got %0h exp 1000", buf_wdata); end
    tick(); #1;                                                        // c6
    checks++; if (buf_wdata !== 14'h0001) begin errors++; $display("FAIL wrap_w2 got %0h exp 1", buf_wdata); end
  endtask

  task automatic test_occ_limit();
    do_reset();
    run = 1'b1;
    tick(); run = 1'b0;                                                // c1
    for (int k = 2; k <= 30; k++) begin                                // c30
      tick(); #1;
      checks++; if (occupancy > 5'd16) begin errors++; $display("FAIL limit_occ_c%0d got %0d exp <=16", k, occupancy); end
    end
    checks++; if (state !== 2'd2 || occupancy !== 5'd16 || buf_write !== 1'b0) begin errors++; $display("FAIL limit_stall got st=%0d occ=%0d wr=%b exp 2 16 0", state, occupancy, buf_write); end
    tick(); decode_ready = 1'b1; #1;                                   // c31
    checks++; if (buf_read !== 1'b1) begin errors++; $display("FAIL limit_read got %b exp 1", buf_read); end
    tick(); decode_ready = 1'b0; #1;                                   // c32
    checks++; if (occupancy !== 5'd14 || buf_write !== 1'b1 || buf_wdata !== 14'h011) begin errors++; $display("FAIL limit_retry got occ=%0d wr=%b data=%0h exp 14 1 11", occupancy, buf_write, buf_wdata); end
    tick(); halt = 1'b1; #1;                                           // c33
    checks++; if (state !== 2'd1 || rom_addr !== 12'h011) begin errors++; $display("FAIL limit_resume got st=%0d pc=%0h exp 1 11", state, rom_addr); end
    for (int i = 0; i < 40 && state !== 2'd0; i++) begin tick(); #1; end
    halt = 1'b0;
    checks++; if (state !== 2'd0 || occupancy !== 5'd15 || rom_addr !== 12'h011) begin errors++; $display("FAIL limit_final got st=%0d occ=%0d pc=%0h exp 0 15 11", state, occupancy, rom_addr); end
    checks++; if (sb.size() != 17) begin errors++; $display("FAIL limit_sb_size got %0d exp 17", sb.size()); end
    for (int i = 0; i < sb.size(); i++) begin
      checks++; if (sb[i] !== 14'(i + 1)) begin errors++; $display("FAIL limit_order%0d got %0h exp %0h", i, sb[i], i + 1); end
    end
  endtask

  task automatic test_halt_stall();
    do_reset();
    run = 1'b1;
    tick(); run = 1'b0;                                                // c1
    for (int k = 2; k <= 4; k++) tick();                               // c4
    tick(); buf_full = 1'b1; #1;                                       // c5: ROM[2] presented
    checks++; if (buf_write !== 1'b1 || buf_wdata !== 14'h3) begin errors++; $display("FAIL hstall_reject got wr=%b data=%0h exp 1 3", buf_write, buf_wdata); end
    tick(); halt = 1'b1; #1;                                           // c6
    checks++; if (state !== 2'd2 || rom_en !== 1'b0) begin errors++; $display("FAIL hstall_stall got st=%0d en=%b exp 2 0", state, rom_en); end
    tick(); buf_full = 1'b0; #1;                                       // c7
    checks++; if (state !== 2'd2 || buf_wdata !== 14'h3) begin errors++; $display("FAIL hstall_retry got st=%0d data=%0h exp 2 3", state, buf_wdata); end
    tick(); halt = 1'b0; run = 1'b1; #1;                               // c8
    checks++; if (state !== 2'd0 || rom_addr !== 12'h003 || occupancy !== 5'd3) begin errors++; $display("FAIL hstall_idle got st=%0d pc=%0h occ=%0d exp 0 3 3", state, rom_addr, occupancy); end
    tick(); run = 1'b0; #1;                                            // c9
    checks++; if (state !== 2'd1 || rom_en !== 1'b1 || rom_addr !== 12'h003) begin errors++; $display("FAIL hstall_resume got st=%0d en=%b pc=%0h exp 1 1 3", state, rom_en, rom_addr); end
    tick(); tick(); #1;                                                // c11
    checks++; if (buf_write !== 1'b1 || buf_wdata !== 14'h4) begin errors++; $display("FAIL hstall_next got wr=%b data=%0h exp 1 4", buf_write, buf_wdata); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_full_retry();
    test_decode_read();
    test_redirect();
    test_wrap();
    test_occ_limit();
    test_halt_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction command buffer between program ROM and DECODE.
- Generates ROM addresses (PC), pushes 14-bit words into the buffer, and retries on buffer-full.
- Issues paired reads to DECODE, tracks buffer occupancy, and handles branch redirect/flush and halt.

Parameters:
- DATA_W, 14, instruction word width (two words form one 28-bit command)
- ADDR_W, 12, ROM address / PC width
- REGS, 16, buffer depth in words; occupancy counter width is clog2(REGS)+1

Ports:
- clk  input  1  system clock; all logic on posedge clk
- reset  input  1  synchronous, active-high reset
- run  input  1  start fetching from IDLE
- halt  input  1  stop fetching after the in-flight word lands
- redirect  input  1  branch taken; 1-cycle pulse
- redirect_addr  input  ADDR_W  new PC on redirect
- rom_en  output  1  ROM read enable
- rom_addr  output  ADDR_W  ROM address
- rom_data  input  DATA_W  ROM data; valid 1 cycle after rom_en
- buf_write  output  1  write strobe to command buffer
- buf_wdata  output  DATA_W  word to buffer
- buf_full  input  1  buffer rejected the write in the same cycle as buf_write
- decode_ready  input  1  DECODE requests a command
- buf_read  output  1  read strobe to buffer (consumes two words)
- flush  output  1  clear-buffer pulse to buffer and DECODE
- occupancy  output  clog2(REGS)+1  words currently held
- state  output  2  FSM state: 0 IDLE, 1 FETCH, 2 STALL, 3 FLUSH

Behaviour:
- Reset:
  - state=IDLE, pc=0, occupancy=0, skid_valid=0.
  - All strobes (rom_en, buf_write, buf_read, flush) are 0; buf_wdata=0, rom_addr=0.
  - Reset mid-operation abandons the in-flight word.
- IDLE:
  - No ROM or buffer activity.
  - run=1 moves to FETCH on the next cycle.
- FETCH:
  - Each cycle: rom_en=1, rom_addr=pc, pc<=pc+1. pc wraps from 2^ADDR_W-1 to 0.
  - An in-flight flag is registered. On the following cycle: buf_write=1, buf_wdata=rom_data.
  - Fetch-to-buffer latency is 2 cycles from the rom_addr cycle.
- Write rejected (buf_write=1 and buf_full=1):
  - Latch the word into the skid register and its address into skid_addr.
  - Drop any ROM read issued in the same cycle; pc<=skid_addr+1.
  - Go to STALL.
- STALL:
  - rom_en=0. Each cycle: buf_write=1, buf_wdata=skid word.
  - First cycle with buf_full=0: word accepted, occupancy+1, return to FETCH.
- Occupancy:
  - +1 on each accepted write.
  - -2 on each buf_read.
  - Write and read in the same cycle: net -1.
  - Never exceeds REGS; reaching REGS forces STALL behaviour before issuing further writes.
- Read side:
  - buf_read=1 for one cycle when decode_ready=1 and occupancy>=2. This holds in any state except FLUSH.
  - occupancy<2 with decode_ready=1: buf_read stays 0 (DECODE waits).
- redirect (highest priority after reset, from any non-IDLE state):
  - flush=1 for exactly one cycle; state=FLUSH.
  - pc<=redirect_addr; skid and in-flight are discarded; occupancy<=0; buf_read is suppressed.
  - Next cycle: FETCH from redirect_addr.
  - redirect in IDLE: only loads pc; no flush.
- halt in FETCH/STALL:
  - Stop issuing rom_en.
  - Finish the pending in-flight or skid word, including STALL retries.
  - Then go to IDLE; pc keeps the next unfetched address.
  - halt and redirect in the same cycle: redirect wins and halt is re-evaluated after FLUSH.
- The write path stays strictly in order; no word is skipped or duplicated across stall or halt.

Optional Feature:
- FETCH_STATS_EN defined:
  - Adds output stall_cycles (16 bit): counts cycles in STALL, saturates at 0xFFFF.
  - Adds output flush_count (8 bit): counts redirects, saturates at 0xFF.
  - Both clear on reset.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Basic fetch: reset, run=1, ROM[0..3]=0x0001..0x0004, buf_full=0.
  - buf_write on cycles 2..5 with data 0x0001..0x0004.
  - occupancy reaches 4.
- Full retry: buf_full=1 on the write of ROM[5] for 3 cycles.
  - state=STALL for 3 cycles, buf_wdata held at ROM[5].
  - Accepted on cycle 4, then ROM[6] follows; no duplicate or skip.
- Decode read: occupancy=3, decode_ready=1 → one buf_read pulse, occupancy=1. Second request with occupancy=1 → no buf_read.
- Redirect: in FETCH at pc=0x010, redirect=1 with redirect_addr=0x200.
  - flush=1 for one cycle, occupancy=0.
  - Next rom_addr=0x200; the in-flight word for 0x010 is never written.
- Wrap: pc=0xFFF in FETCH → next rom_addr=0x000.
- Halt during STALL: retry completes, then state=IDLE and pc equals rejected address+1. A later run resumes from that pc.
